// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: branch modes and sequencer states.
package fetch_pkg;

  typedef enum logic [1:0] {
    ABS  = 2'b00,
    REL  = 2'b01,
    CALL = 2'b10,
    RET  = 2'b11
  } br_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// Fetch sequencer bus: redirect/halt/stall controls in, fetch address and status out.
interface fetch_seq_if #(
  parameter int PC_W      = 9,
  parameter int CNT_W     = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int LVL_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  start_addr;
  logic             branch;
  logic [1:0]       br_mode;
  logic [PC_W-1:0]  target;
  logic             halt_req;
  logic             stall;
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic             halted;
  logic [CNT_W-1:0] instr_count;
  logic             ras_ovf;
  logic             ras_unf;
  logic [LVL_W-1:0] ras_level;

  modport master (
    output start_addr, branch, br_mode, target, halt_req, stall,
    input  pc, pc_valid, halted, instr_count, ras_ovf, ras_unf, ras_level
  );

  modport slave (
    input  start_addr, branch, br_mode, target, halt_req, stall,
    output pc, pc_valid, halted, instr_count, ras_ovf, ras_unf, ras_level
  );
endinterface

// File: rtl/ras.sv
// Return-address stack on circular storage; a push when full overwrites the oldest entry.
module ras #(
  parameter int PC_W  = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [PC_W-1:0]            data_i,
  output logic [PC_W-1:0]            top_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d, wp_inc, rp;
  logic [LVL_W-1:0] lvl_q, lvl_d;

  // wp points at the next free slot; the top of stack sits one slot behind it
  assign rp      = (wp_q == '0) ? PTR_W'(DEPTH - 1) : wp_q - PTR_W'(1);
  assign wp_inc  = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
  assign top_o   = mem_q[rp];
  assign full_o  = (lvl_q == LVL_W'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;

  always_comb begin
    wp_d  = wp_q;
    lvl_d = lvl_q;
    if (push_i) begin
      wp_d = wp_inc;
      if (!full_o) lvl_d = lvl_q + LVL_W'(1);
    end else if (pop_i && !empty_o) begin
      wp_d  = rp;
      lvl_d = lvl_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      wp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wp_q] <= data_i;
  end
endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: PC update, call/return stack, halt and commit counting.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int CNT_W     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        start,
  fetch_seq_if.slave  bus
);
  localparam int LVL_W = $clog2(RAS_DEPTH + 1);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop;
  logic [PC_W-1:0]  ras_top;
  logic [LVL_W-1:0] ras_level;
  logic             ras_full, ras_empty;

  ras #(.PC_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .clear_i (start),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (ras_top),
    .level_o (ras_level),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (!bus.stall) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (bus.halt_req) begin
            state_d = HALTED;
          end else if (!bus.branch) begin
            pc_d = pc_inc;
          end else begin
            case (br_mode_t'(bus.br_mode))
              ABS:  pc_d = bus.target;
              REL:  pc_d = pc_q + bus.target;
              CALL: begin
                push = 1'b1;
                pc_d = bus.target;
                if (ras_full) ovf_d = 1'b1;
              end
              RET: begin
                if (ras_empty) begin
                  pc_d  = pc_inc;
                  unf_d = 1'b1;
                end else begin
                  pop  = 1'b1;
                  pc_d = ras_top;
                end
              end
              default: pc_d = pc_inc;
            endcase
          end
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state_q <= IDLE;
      pc_q    <= bus.start_addr;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_valid    = (state_q == RUN);
  assign bus.halted      = (state_q == HALTED);
  assign bus.instr_count = cnt_q;
  assign bus.ras_ovf     = ovf_q;
  assign bus.ras_unf     = unf_q;
  assign bus.ras_level   = ras_level;
endmodule

// File: tb/tb_fetch_seq.sv
// Directed vector bench for fetch_seq plus a saturating-counter instance with CNT_W=4.
module tb_fetch_seq;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic start9, start4;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_seq_if #(.PC_W(9), .CNT_W(16), .RAS_DEPTH(4)) bus9 ();
  fetch_seq_if #(.PC_W(9), .CNT_W(4),  .RAS_DEPTH(4)) bus4 ();

  fetch_seq #(.PC_W(9), .CNT_W(16), .RAS_DEPTH(4)) dut9 (
    .clk(clk), .start(start9), .bus(bus9)
  );
  fetch_seq #(.PC_W(9), .CNT_W(4), .RAS_DEPTH(4)) dut4 (
    .clk(clk), .start(start4), .bus(bus4)
  );

  typedef struct {
    logic        st;
    logic [8:0]  addr;
    logic        br;
    br_mode_t    mode;
    logic [8:0]  tgt;
    logic        halt;
    logic        stall;
    logic [8:0]  pc;
    logic        vld;
    logic        hlt;
    logic [15:0] cnt;
    logic [2:0]  lvl;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic st, logic [8:0] addr, logic br, br_mode_t mode,
                             logic [8:0] tgt, logic halt, logic stall,
                             logic [8:0] pc, logic vld, logic hlt, logic [15:0] cnt,
                             logic [2:0] lvl, logic ovf, logic unf);
    vec_t r;
    r.st = st; r.addr = addr; r.br = br; r.mode = mode; r.tgt = tgt;
    r.halt = halt; r.stall = stall; r.pc = pc; r.vld = vld; r.hlt = hlt;
    r.cnt = cnt; r.lvl = lvl; r.ovf = ovf; r.unf = unf;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // st addr br mode tgt halt stall | pc vld hlt cnt lvl ovf unf
    // start/release, sequential fetch
    vecs.push_back(v(1, 9'h010, 0, ABS,  9'h000, 0, 0,  9'h010, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h010, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h011, 1, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h012, 1, 0, 2, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h013, 1, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h014, 1, 0, 4, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, ABS,  9'h100, 1, 1,  9'h014, 1, 0, 4, 0, 0, 0));
    // pc wrap, ABS, negative REL
    vecs.push_back(v(1, 9'h1FE, 0, ABS,  9'h000, 0, 0,  9'h1FE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h1FE, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h1FF, 1, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h000, 1, 0, 2, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, ABS,  9'h005, 0, 0,  9'h005, 1, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, REL,  9'h1FD, 0, 0,  9'h002, 1, 0, 4, 0, 0, 0));
    // single call/return
    vecs.push_back(v(0, 9'h000, 1, ABS,  9'h020, 0, 0,  9'h020, 1, 0, 5, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, CALL, 9'h040, 0, 0,  9'h040, 1, 0, 6, 1, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, RET,  9'h000, 0, 0,  9'h021, 1, 0, 7, 0, 0, 0));
    // nested calls past depth, then unwind past empty
    vecs.push_back(v(1, 9'h100, 0, ABS,  9'h000, 0, 0,  9'h100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h100, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, CALL, 9'h110, 0, 0,  9'h110, 1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, CALL, 9'h120, 0, 0,  9'h120, 1, 0, 2, 2, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, CALL, 9'h130, 0, 0,  9'h130, 1, 0, 3, 3, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, CALL, 9'h140, 0, 0,  9'h140, 1, 0, 4, 4, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, CALL, 9'h150, 0, 0,  9'h150, 1, 0, 5, 4, 1, 0));
    vecs.push_back(v(0, 9'h000, 1, RET,  9'h000, 0, 0,  9'h141, 1, 0, 6, 3, 1, 0));
    vecs.push_back(v(0, 9'h000, 1, RET,  9'h000, 0, 0,  9'h131, 1, 0, 7, 2, 1, 0));
    vecs.push_back(v(0, 9'h000, 1, RET,  9'h000, 0, 0,  9'h121, 1, 0, 8, 1, 1, 0));
    vecs.push_back(v(0, 9'h000, 1, RET,  9'h000, 0, 0,  9'h111, 1, 0, 9, 0, 1, 0));
    vecs.push_back(v(0, 9'h000, 1, RET,  9'h000, 0, 0,  9'h112, 1, 0, 10, 0, 1, 1));
    // restart clears sticky flags; halt under stall, halt commit, restart from HALTED
    vecs.push_back(v(1, 9'h030, 0, ABS,  9'h000, 0, 0,  9'h030, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h030, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, CALL, 9'h050, 0, 0,  9'h050, 1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, ABS,  9'h0AA, 1, 1,  9'h050, 1, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, ABS,  9'h0AA, 1, 0,  9'h050, 0, 1, 2, 1, 0, 0));
    vecs.push_back(v(0, 9'h000, 1, CALL, 9'h070, 0, 0,  9'h050, 0, 1, 2, 1, 0, 0));
    vecs.push_back(v(1, 9'h0F0, 1, CALL, 9'h070, 1, 1,  9'h0F0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h0F0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 9'h000, 0, ABS,  9'h000, 0, 0,  9'h0F1, 1, 0, 1, 0, 0, 0));

    start4 = 1'b1;
    bus4.start_addr = 9'h1F0;
    bus4.branch = 1'b0; bus4.br_mode = 2'b00; bus4.target = '0;
    bus4.halt_req = 1'b0; bus4.stall = 1'b0;

    foreach (vecs[i]) begin
      start9          = vecs[i].st;
      bus9.start_addr = vecs[i].addr;
      bus9.branch     = vecs[i].br;
      bus9.br_mode    = vecs[i].mode;
      bus9.target     = vecs[i].tgt;
      bus9.halt_req   = vecs[i].halt;
      bus9.stall      = vecs[i].stall;
      @(posedge clk); #1;
      chk($sformatf("r%0d.pc", i),    32'(bus9.pc),          32'(vecs[i].pc));
      chk($sformatf("r%0d.vld", i),   32'(bus9.pc_valid),    32'(vecs[i].vld));
      chk($sformatf("r%0d.hlt", i),   32'(bus9.halted),      32'(vecs[i].hlt));
      chk($sformatf("r%0d.cnt", i),   32'(bus9.instr_count), 32'(vecs[i].cnt));
      chk($sformatf("r%0d.lvl", i),   32'(bus9.ras_level),   32'(vecs[i].lvl));
      chk($sformatf("r%0d.ovf", i),   32'(bus9.ras_ovf),     32'(vecs[i].ovf));
      chk($sformatf("r%0d.unf", i),   32'(bus9.ras_unf),     32'(vecs[i].unf));
    end

    // CNT_W=4 instance: reset values, then 20 commits saturating at 15
    chk("sat.reset_cnt", 32'(bus4.instr_count), 32'd0);
    chk("sat.reset_vld", 32'(bus4.pc_valid), 32'd0);
    start4 = 1'b0;
    @(posedge clk); #1;
    chk("sat.idle_pc", 32'(bus4.pc), 32'h1F0);
    chk("sat.run_vld", 32'(bus4.pc_valid), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat.cnt%0d", i), 32'(bus4.instr_count), (i > 15) ? 32'd15 : 32'(i));
    end
    chk("sat.pc_wrap", 32'(bus4.pc), 32'h004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
